// File: rtl/usm_vector_feeder.sv
// usm_vector_feeder
//   Producer side of the USM pixel-vector interface. Collects a raster pixel
//   stream into overlapping LENGTH-pixel vectors. Successive vectors advance
//   by STEP = LENGTH-COV_SIZE+1 pixels. Row edges are padded by replicating
//   the edge pixel, so every row yields ROW_WIDTH convolution outputs
//   downstream.
//
// Ports
//   clk      in   1                 clock
//   rst_n    in   1                 asynchronous active-low reset
//   s_valid  in   1                 input pixel valid
//   s_ready  out  1                 pixel accepted when s_valid && s_ready
//   s_data   in   CH_WIDTH          input pixel, raster order
//   m_valid  out  1                 output vector valid
//   m_ready  in   1                 downstream accepts vector
//   m_data   out  CH_WIDTH*LENGTH   vector, element k at [k*CH_WIDTH +: CH_WIDTH]
//   m_sor    out  1                 first vector of row (qualified by m_valid)
//   m_eor    out  1                 last vector of row (qualified by m_valid)
//
// State  | meaning
// -------+-------------------------------------------------------------
// FILL   | accepting pixels into the window
// PAD_R  | replicating the last pixel of the row into the window tail
// EMIT   | presenting the window downstream, waiting for m_ready

module usm_vector_feeder #(
    parameter int LENGTH    = 10,
    parameter int COV_SIZE  = 3,
    parameter int CH_WIDTH  = 8,
    parameter int ROW_WIDTH = 960
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [CH_WIDTH-1:0]          s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [CH_WIDTH*LENGTH-1:0]   m_data,
    output logic                         m_sor,
    output logic                         m_eor
);

    localparam int PAD   = (COV_SIZE - 1) / 2;
    localparam int STEP  = LENGTH - COV_SIZE + 1;
    localparam int CNT_W = $clog2(LENGTH + 1);
    localparam int COL_W = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PAD_R = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CH_WIDTH-1:0]   r_win [LENGTH];
    logic [CNT_W-1:0]      r_cnt;
    logic [COL_W-1:0]      r_col;
    logic                  r_row_start;
    logic                  r_sor;
    logic                  r_eor;
    // Keeps s_ready low while reset is asserted and for the first cycle after.
    logic                  r_run;

    logic                  w_accept;
    logic                  w_last_col;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [CNT_W-1:0]      w_fill_cnt;

    assign w_accept   = s_valid && s_ready;
    assign w_last_col = (r_col == COL_W'(ROW_WIDTH - 1));
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    // Fill level after the pixel being accepted this cycle.
    assign w_fill_cnt = r_row_start ? CNT_W'(PAD + 1) : w_cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        s_ready      = 1'b0;
        m_valid      = 1'b0;
        case (r_state)
            FILL: begin
                s_ready = r_run;
                if (w_accept) begin
                    // End of row wins even if the window also just filled.
                    if (w_last_col) begin
                        w_next_state = PAD_R;
                    end else if (w_fill_cnt == CNT_W'(LENGTH)) begin
                        w_next_state = EMIT;
                    end
                end
            end
            PAD_R: begin
                if (w_cnt_inc == CNT_W'(LENGTH)) begin
                    w_next_state = EMIT;
                end
            end
            EMIT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    w_next_state = FILL;
                end
            end
            default: w_next_state = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LENGTH; k++) begin
                r_win[k] <= '0;
            end
            r_cnt       <= '0;
            r_col       <= '0;
            r_row_start <= 1'b1;
            r_sor       <= 1'b0;
            r_eor       <= 1'b0;
            r_run       <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (r_row_start) begin
                            // Left padding: the first pixel fills slots 0..PAD.
                            for (int k = 0; k <= PAD; k++) begin
                                r_win[k] <= s_data;
                            end
                            r_row_start <= 1'b0;
                            r_sor       <= 1'b1;
                        end else begin
                            for (int k = 0; k < LENGTH; k++) begin
                                if (CNT_W'(k) == r_cnt) begin
                                    r_win[k] <= s_data;
                                end
                            end
                        end
                        r_cnt <= w_fill_cnt;
                        r_col <= w_last_col ? '0 : r_col + COL_W'(1);
                    end
                end
                PAD_R: begin
                    for (int k = 1; k < LENGTH; k++) begin
                        if (CNT_W'(k) == r_cnt) begin
                            r_win[k] <= r_win[k-1];
                        end
                    end
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_inc == CNT_W'(LENGTH)) begin
                        r_eor <= 1'b1;
                    end
                end
                EMIT: begin
                    if (m_ready) begin
                        if (r_eor) begin
                            r_cnt       <= '0;
                            r_row_start <= 1'b1;
                            r_eor       <= 1'b0;
                        end else begin
                            // Keep the COV_SIZE-1 pixel overlap for the next vector.
                            for (int k = 0; k < COV_SIZE - 1; k++) begin
                                r_win[k] <= r_win[k+STEP];
                            end
                            r_cnt <= CNT_W'(COV_SIZE - 1);
                        end
                        r_sor <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m_data = '0;
        for (int k = 0; k < LENGTH; k++) begin
            m_data[k*CH_WIDTH +: CH_WIDTH] = r_win[k];
        end
    end

    assign m_sor = r_sor && m_valid;
    assign m_eor = r_eor && m_valid;

endmodule
